// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and FSM encoding for the display front end
package seg_pkg;

    localparam int DIGITS = 8;
    localparam logic [26:0] BCD_MAX = 27'd99_999_999;
    localparam logic [3:0] BLANK_CODE_DEF = 4'hF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between producer and bin2bcd_seq
interface bin2bcd_seq_if #(
    parameter int WIDTH = 27
) ();

    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       number0;
    logic [3:0]       number1;
    logic [3:0]       number2;
    logic [3:0]       number3;
    logic [3:0]       number4;
    logic [3:0]       number5;
    logic [3:0]       number6;
    logic [3:0]       number7;

    modport master (
        output start, bin,
        input  busy, done, overflow,
        input  number0, number1, number2, number3,
        input  number4, number5, number6, number7
    );

    modport slave (
        input  start, bin,
        output busy, done, overflow,
        output number0, number1, number2, number3,
        output number4, number5, number6, number7
    );

endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit corrector: add 3 when digit >= 5
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A digit of 5..9 would become >= 10 after the shift, so pre-correct it.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter with registered digit outputs
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int         WIDTH      = 27,
    parameter bit         LZ_BLANK   = 1'b0,
    parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic              capture;
    logic              load;

    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_next;
    logic [CW-1:0]     cnt;
    logic              ovf_pend;
    logic [31:0]       bin_ext;
    logic              bin_over;
    logic              unused_top;

    logic [3:0]        fmt   [DIGITS];
    logic [3:0]        num_q [DIGITS];
    logic              done_q;
    logic              ovf_q;
    logic              nz_above;

    // Narrower inputs are zero-extended, so they can never exceed BCD_MAX.
    assign bin_ext  = 32'(bus.bin);
    assign bin_over = (bin_ext > 32'(BCD_MAX));

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (bcd[4*g +: 4]),
                .dout (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    // Only reachable for values above BCD_MAX, which are reported as overflow.
    assign unused_top = bcd_adj[BW-1];
    assign bcd_next   = {bcd_adj[BW-2:0], shreg[WIDTH-1]};

    // State register; rst aborts any conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the capture/load strobes for the datapath.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SHIFT;
                    capture   = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    load      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift engine: capture the operand, then one add-3/shift step per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else if (capture) begin
            shreg    <= bus.bin;
            bcd      <= '0;
            cnt      <= CNT_INIT;
            ovf_pend <= bin_over;
        end else if (state == SHIFT) begin
            shreg    <= shreg << 1;
            bcd      <= bcd_next;
            cnt      <= cnt - 1'b1;
        end
    end

    // Final digit formatting: saturate on overflow, else optional leading-zero blanking.
    always_comb begin
        nz_above = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            fmt[i] = '0;
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_pend) begin
                fmt[i] = 4'd9;
            end else if (LZ_BLANK && (i != 0) && !nz_above && (bcd_next[4*i +: 4] == 4'd0)) begin
                fmt[i] = BLANK_CODE;
            end else begin
                fmt[i] = bcd_next[4*i +: 4];
            end
            if (bcd_next[4*i +: 4] != 4'd0) begin
                nz_above = 1'b1;
            end
        end
    end

    // Output snapshot: digits and overflow change only on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                num_q[i] <= '0;
            end
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= load;
            if (load) begin
                for (int i = 0; i < DIGITS; i++) begin
                    num_q[i] <= fmt[i];
                end
                ovf_q <= ovf_pend;
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.number0  = num_q[0];
    assign bus.number1  = num_q[1];
    assign bus.number2  = num_q[2];
    assign bus.number3  = num_q[3];
    assign bus.number4  = num_q[4];
    assign bus.number5  = num_q[5];
    assign bus.number6  = num_q[6];
    assign bus.number7  = num_q[7];

endmodule
